// File: rtl/dds_clk_pkg.sv
// dds_clk_pkg: shared types and constants for the DDS slow-clock divider.
package dds_clk_pkg;
   typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;
   localparam int MIN_DIV = 2;
   localparam int DEF_COUNTER_SIZE = 15;
endpackage

// File: rtl/clock_divider_ctrl_period_counter.sv
// period_counter: counts 0..div-1 while running, held at zero while cleared.
module period_counter
   import dds_clk_pkg::*;
#(
   parameter int COUNTER_SIZE = DEF_COUNTER_SIZE
) (
   input  logic                    fast_clock,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    run,
   input  logic [COUNTER_SIZE-1:0] div,
   output logic [COUNTER_SIZE-1:0] count,
   output logic                    wrap,
   output logic [COUNTER_SIZE-1:0] next_count
);
   assign wrap = run && count == div - COUNTER_SIZE'(1);
   assign next_count = (clear || wrap) ? '0 : run ? count + COUNTER_SIZE'(1) : count;
   always_ff @(posedge fast_clock or negedge rst)
      if (!rst) count <= '0;
      else count <= next_count;
endmodule

// File: rtl/clock_divider_ctrl.sv
// clock_divider_ctrl: run/stop FSM and boundary-safe ratio update for the divided slow clock.
module clock_divider_ctrl
   import dds_clk_pkg::*;
#(
   parameter int COUNTER_SIZE = DEF_COUNTER_SIZE,
   parameter int DEFAULT_DIV  = 32767
) (
   input  logic                    fast_clock,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    cfg_valid,
   input  logic [COUNTER_SIZE-1:0] cfg_div,
   output logic                    cfg_ready,
   output logic                    cfg_err,
   output logic                    tick,
   output logic                    slow_clock,
   output logic                    busy,
   output logic [COUNTER_SIZE-1:0] cur_div
);
   state_t                  state, next_state;
   logic                    pend, wrap, xfer, bad, load, apply;
   logic [COUNTER_SIZE-1:0] pend_div, next_div, next_count, count_unused;
   period_counter #(.COUNTER_SIZE(COUNTER_SIZE)) u_cnt (
      .fast_clock(fast_clock),
      .rst(rst),
      .clear(state == STOP),
      .run(state == RUN),
      .div(cur_div),
      .count(count_unused),
      .wrap(wrap),
      .next_count(next_count)
   );
   assign cfg_ready = !pend;
   assign xfer = cfg_valid && cfg_ready;
   assign bad = cfg_div < COUNTER_SIZE'(MIN_DIV);
   assign load = xfer && !bad;
   // a value queued on the final wrap before stopping is applied on the first STOP edge
   assign apply = pend && (wrap || state == STOP);
   always_comb begin
      next_state = (state == STOP) ? (enable ? RUN : STOP) : ((wrap && !enable) ? STOP : RUN);
      next_div = apply ? pend_div : (load && state == STOP) ? cfg_div : cur_div;
   end
   always_ff @(posedge fast_clock or negedge rst)
      if (!rst) begin
         state      <= STOP;
         cur_div    <= COUNTER_SIZE'(DEFAULT_DIV);
         pend       <= 1'b0;
         pend_div   <= '0;
         tick       <= 1'b0;
         slow_clock <= 1'b0;
         busy       <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         state      <= next_state;
         cur_div    <= next_div;
         pend       <= apply ? 1'b0 : (load && state == RUN) ? 1'b1 : pend;
         if (load && state == RUN) pend_div <= cfg_div;
         tick       <= next_state == RUN && next_count == next_div - COUNTER_SIZE'(1);
         slow_clock <= next_state == RUN && next_count < (next_div >> 1);
         busy       <= next_state == RUN;
         cfg_err    <= xfer && bad;
      end
endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb_clock_divider_ctrl: scoreboard bench with a period-level reference model.
module tb_clock_divider_ctrl;
   logic        fast_clock = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [14:0] cfg_div = '0;
   logic        cfg_ready, cfg_err, tick, slow_clock, busy;
   logic [14:0] cur_div;

   clock_divider_ctrl dut (
      .fast_clock(fast_clock),
      .rst(rst),
      .enable(enable),
      .cfg_valid(cfg_valid),
      .cfg_div(cfg_div),
      .cfg_ready(cfg_ready),
      .cfg_err(cfg_err),
      .tick(tick),
      .slow_clock(slow_clock),
      .busy(busy),
      .cur_div(cur_div)
   );

   always #5 fast_clock = ~fast_clock;

   typedef struct {
      bit tick;
      bit slow;
      bit busy;
      bit err;
      bit ready;
      int div;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // model: running flag, position within the period, ratio in effect, queued ratios
   int   m_run, m_phase, m_div, m_err;
   int   pq[$];

   function automatic void mreset();
      m_run = 0;
      m_phase = 0;
      m_div = 32767;
      m_err = 0;
      pq.delete();
   endfunction

   function automatic void step(bit e, bit v, int d);
      bit xfer, bad;
      xfer = v && pq.size() == 0;
      bad = d < 2;
      m_err = int'(xfer && bad);
      if (m_run != 0) begin
         if (m_phase == m_div - 1) begin
            m_phase = 0;
            if (pq.size() != 0) m_div = pq.pop_front();
            m_run = int'(e);
         end else m_phase++;
         if (xfer && !bad) pq.push_back(d);
      end else begin
         if (pq.size() != 0) m_div = pq.pop_front();
         else if (xfer && !bad) m_div = d;
         m_run = int'(e);
         m_phase = 0;
      end
   endfunction

   function automatic exp_t expv();
      exp_t x;
      x.tick = m_run != 0 && m_phase == m_div - 1;
      x.slow = m_run != 0 && m_phase < m_div / 2;
      x.busy = m_run != 0;
      x.err = m_err != 0;
      x.ready = pq.size() == 0;
      x.div = m_div;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic cmp(input string tag, input exp_t x);
      chk({tag, ".tick"}, 32'(tick), 32'(x.tick));
      chk({tag, ".slow_clock"}, 32'(slow_clock), 32'(x.slow));
      chk({tag, ".busy"}, 32'(busy), 32'(x.busy));
      chk({tag, ".cfg_err"}, 32'(cfg_err), 32'(x.err));
      chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(x.ready));
      chk({tag, ".cur_div"}, 32'(cur_div), 32'(x.div));
   endtask

   always @(posedge fast_clock) begin
      #1;
      if (sb.size() != 0) cmp("cycle", sb.pop_front());
   end

   task automatic cyc(input bit e, input bit v, input int d);
      @(negedge fast_clock);
      rst = 1'b1;
      enable = e;
      cfg_valid = v;
      cfg_div = 15'(d);
      step(e, v, d);
      sb.push_back(expv());
   endtask

   task automatic areset();
      @(negedge fast_clock);
      rst = 1'b0;
      enable = 1'b0;
      cfg_valid = 1'b0;
      mreset();
      #1;
      cmp("async_reset", expv());
      sb.push_back(expv());
   endtask

   task automatic wait_phase(input int p);
      int n = 0;
      while (!(m_run != 0 && m_phase == p) && n < 100) begin
         cyc(1'b1, 1'b0, 0);
         n++;
      end
      if (n == 100) begin
         checks++;
         errors++;
         $display("FAIL wait_phase: phase %0d not reached within 100 cycles", p);
      end
   endtask

   initial begin
      mreset();
      areset();
      repeat (100) cyc(1'b0, 1'b0, 0);
      cyc(1'b0, 1'b1, 4);
      repeat (12) cyc(1'b1, 1'b0, 0);
      wait_phase(1);
      cyc(1'b1, 1'b1, 7);
      repeat (20) cyc(1'b1, 1'b0, 0);
      wait_phase(1);
      cyc(1'b1, 1'b1, 4);
      repeat (16) cyc(1'b1, 1'b0, 0);
      wait_phase(3);
      cyc(1'b1, 1'b1, 7);
      repeat (16) cyc(1'b1, 1'b0, 0);
      wait_phase(1);
      cyc(1'b1, 1'b1, 5);
      repeat (14) cyc(1'b1, 1'b0, 0);
      wait_phase(1);
      repeat (10) cyc(1'b0, 1'b0, 0);
      cyc(1'b0, 1'b1, 1);
      cyc(1'b0, 1'b1, 0);
      repeat (3) cyc(1'b0, 1'b0, 0);
      repeat (2) cyc(1'b1, 1'b0, 0);
      cyc(1'b1, 1'b1, 0);
      wait_phase(1);
      cyc(1'b1, 1'b1, 9);
      cyc(1'b1, 1'b0, 0);
      areset();
      repeat (3) cyc(1'b0, 1'b0, 0);
      cyc(1'b0, 1'b1, 6);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            areset();
            cyc(1'b0, 1'b1, int'($urandom_range(2, 9)));
         end else
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 10)));
      end
      repeat (2) @(negedge fast_clock);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
